cordic_atan2_seq: RTL and testbench

//  Iterative fixed-point CORDIC vectoring engine. Converts a Cartesian pair (x,y) into polar form
//  (angle = atan2(y,x), magnitude = sqrt(x^2+y^2)), one micro-rotation per clock.
//  It is the inverse of the sin/cos generators in the math package: synthesizable, no real types.

---
 rtl/cordic_atan2_seq.sv | 183 ++++++++++++++++++
 tb/tb_cordic_atan2_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_atan2_seq.sv
// Iterative CORDIC vectoring engine: (x,y) -> (atan2 binary angle, gain-compensated magnitude),
// one micro-rotation per clock behind a valid/ready handshake on each side.
module cordic_atan2_seq #(
    parameter int W       = 16,
    parameter int ANGLE_W = 16,
    parameter int ITER    = 16,
    parameter int GAIN_Q  = 39797
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [W-1:0]       in_x,
    input  logic signed [W-1:0]       in_y,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [ANGLE_W-1:0] out_angle,
    output logic [W:0]                out_mag
);

    localparam int XW = W + 2;
    localparam int ZW = ANGLE_W + 1;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW = XW + 17;
    localparam logic signed [ZW-1:0] QUARTER = ZW'(2 ** (ANGLE_W - 2));

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_SCALE, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic signed [XW-1:0]       x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0]       z_q, z_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       zero_q, zero_d;
    logic signed [ANGLE_W-1:0]  angle_q, angle_d;
    logic [W:0]                 mag_q, mag_d;

    // atan(2^-i)/pi scaled by 2^31; rescaled to the configured angle width with rounding.
    function automatic logic [31:0] atan_ref(input logic [4:0] idx);
        case (idx)
            5'd0:  return 32'd536870912;
            5'd1:  return 32'd316933406;
            5'd2:  return 32'd167458907;
            5'd3:  return 32'd85004756;
            5'd4:  return 32'd42667331;
            5'd5:  return 32'd21354465;
            5'd6:  return 32'd10679838;
            5'd7:  return 32'd5340245;
            5'd8:  return 32'd2670163;
            5'd9:  return 32'd1335087;
            5'd10: return 32'd667544;
            5'd11: return 32'd333772;
            5'd12: return 32'd166886;
            5'd13: return 32'd83443;
            5'd14: return 32'd41721;
            5'd15: return 32'd20860;
            5'd16: return 32'd10430;
            5'd17: return 32'd5215;
            5'd18: return 32'd2608;
            5'd19: return 32'd1304;
            5'd20: return 32'd652;
            5'd21: return 32'd326;
            5'd22: return 32'd163;
            5'd23: return 32'd81;
            5'd24: return 32'd41;
            5'd25: return 32'd20;
            5'd26: return 32'd10;
            5'd27: return 32'd5;
            5'd28: return 32'd3;
            5'd29: return 32'd1;
            5'd30: return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic signed [ZW-1:0] atan_step(input logic [4:0] idx);
        return ZW'((({32'd0, atan_ref(idx)} << ANGLE_W) + 64'h8000_0000) >> 32);
    endfunction

    function automatic logic [W:0] scale_mag(input logic signed [XW-1:0] x);
        logic [PW-1:0] prod;
        prod = PW'($unsigned(x)) * PW'(GAIN_Q) + PW'(1 << 15);
        return (W+1)'(prod >> 16);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_PRE;
            S_PRE:   state_d = S_ITER;
            S_ITER:  if (cnt_q == CW'(ITER - 1)) state_d = S_SCALE;
            S_SCALE: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        mag_d   = mag_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d    = {{2{in_x[W-1]}}, in_x};
                    y_d    = {{2{in_y[W-1]}}, in_y};
                    z_d    = '0;
                    zero_d = (in_x == '0) && (in_y == '0);
                end
            end
            // Fold left half-plane into the right so the rotations only need +-pi/2 of range.
            S_PRE: begin
                cnt_d = '0;
                if (x_q[XW-1]) begin
                    if (!y_q[XW-1]) begin
                        x_d = y_q;
                        y_d = -x_q;
                        z_d = QUARTER;
                    end else begin
                        x_d = -y_q;
                        y_d = x_q;
                        z_d = -QUARTER;
                    end
                end
            end
            S_ITER: begin
                cnt_d = cnt_q + CW'(1);
                if (!y_q[XW-1]) begin
                    x_d = x_q + (y_q >>> cnt_q);
                    y_d = y_q - (x_q >>> cnt_q);
                    z_d = z_q + atan_step(5'(cnt_q));
                end else begin
                    x_d = x_q - (y_q >>> cnt_q);
                    y_d = y_q + (x_q >>> cnt_q);
                    z_d = z_q - atan_step(5'(cnt_q));
                end
            end
            // A zero vector would otherwise accumulate every table entry into the angle.
            S_SCALE: begin
                mag_d   = scale_mag(x_q);
                angle_d = zero_q ? '0 : z_q[ANGLE_W-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    assign out_angle = angle_q;
    assign out_mag   = mag_q;

endmodule

// File: tb/tb_cordic_atan2_seq.sv
// Self-checking bench for cordic_atan2_seq: directed corners, handshake stall, mid-run reset,
// and random vectors compared against a real-valued atan2/hypot model.
module tb_cordic_atan2_seq;

    localparam int  W     = 16;
    localparam int  AW    = 16;
    localparam int  ITER  = 16;
    localparam real PI    = 3.14159265358979323846;
    localparam real KGAIN = 1.6467602581;
    localparam real LSB_PER_RAD = 32768.0 / PI;
    localparam int  MAG_TOL = 12;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [W-1:0]  in_x = '0;
    logic signed [W-1:0]  in_y = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [AW-1:0] out_angle;
    logic [W:0]           out_mag;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cordic_atan2_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_angle (out_angle),
        .out_mag   (out_mag)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_ang(input string tag, input int got, input real exp, input int tol);
        int e, d;
        e = int'(exp);
        if (e >= 32768) e -= 65536;
        d = got - e;
        while (d > 32767) d -= 65536;
        while (d < -32768) d += 65536;
        n_assert++;
        assert (d >= -tol && d <= tol) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +-%0d", tag, got, e, tol);
        end
    endtask

    task automatic chk_mag(input string tag, input int got, input real exp, input int tol);
        int e, d;
        e = int'(exp);
        d = got - e;
        n_assert++;
        assert (d >= -tol && d <= tol) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +-%0d", tag, got, e, tol);
        end
    endtask

    // Reference: exact atan2/hypot; angle tolerance widens for short vectors whose
    // integer datapath resolution is about one unit of the gain-scaled x.
    task automatic check_model(input string tag, input int x, input int y,
                               input logic signed [AW-1:0] ang, input logic [W:0] mag);
        real xr, yr, ea, em;
        int  tol;
        if (x == 0 && y == 0) begin
            chk({tag, " zero angle"}, ang, 0);
            chk({tag, " zero mag"}, mag, 0);
        end else begin
            xr  = $itor(x);
            yr  = $itor(y);
            ea  = $atan2(yr, xr) * LSB_PER_RAD;
            em  = $sqrt(xr * xr + yr * yr);
            tol = 5 + int'($ceil(8.0 * LSB_PER_RAD / (em * KGAIN)));
            chk_ang({tag, " angle"}, int'(ang), ea, tol);
            chk_mag({tag, " mag"}, int'(mag), em, MAG_TOL);
        end
    endtask

    task automatic run_op(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                          input string tag,
                          output logic signed [AW-1:0] ang, output logic [W:0] mag);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " in_ready"}, in_ready, 1);
        in_x = x;
        in_y = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x = W'($urandom);
        in_y = W'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, cyc, ITER + 2);
        ang = out_angle;
        mag = out_mag;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " release"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic signed [AW-1:0] ang, sa;
        logic [W:0]           mag, sm;
        logic signed [W-1:0]  rx, ry;
        int                   cyc;
        int dx [6] = '{1000, 0,    1000, -1000, -32768, 0};
        int dy [6] = '{0,    1000, 1000, 0,     -32768, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset angle", out_angle, 0);
        chk("reset mag", out_mag, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-reset in_ready", in_ready, 1);
        chk("post-reset out_valid", out_valid, 0);

        for (int k = 0; k < 6; k++) begin
            run_op(W'(dx[k]), W'(dy[k]), $sformatf("dir%0d", k), ang, mag);
            check_model($sformatf("dir%0d", k), dx[k], dy[k], ang, mag);
        end

        // Consumer stalls in DONE while the producer keeps poking in_valid.
        in_x = 3000;
        in_y = -4000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall latency", cyc, ITER + 2);
        sa = out_angle;
        sm = out_mag;
        check_model("stall", 3000, -4000, sa, sm);
        for (int k = 0; k < 5; k++) begin
            in_valid = ~k[0];
            in_x = W'($urandom);
            in_y = W'($urandom);
            @(posedge clk); #1;
            chk("stall out_valid", out_valid, 1);
            chk("stall angle held", out_angle, sa);
            chk("stall mag held", out_mag, sm);
            chk("stall in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall release in_ready", in_ready, 1);
        chk("stall release out_valid", out_valid, 0);
        run_op(-12345, 6789, "after stall", ang, mag);
        check_model("after stall", -12345, 6789, ang, mag);

        // Reset in the middle of the rotations, with a previous nonzero result still on the outputs.
        run_op(20000, 15000, "pre-reset", ang, mag);
        check_model("pre-reset", 20000, 15000, ang, mag);
        in_x = 7000;
        in_y = -9000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid reset out_valid", out_valid, 0);
        chk("mid reset angle", out_angle, 0);
        chk("mid reset mag", out_mag, 0);
        chk("mid reset in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (ITER + 4) @(posedge clk);
        #1;
        chk("no stale result", out_valid, 0);
        run_op(7000, -9000, "post-reset op", ang, mag);
        check_model("post-reset op", 7000, -9000, ang, mag);

        for (int k = 0; k < 300; k++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            if (k % 3 == 1) begin
                rx = rx >>> $urandom_range(1, 10);
                ry = ry >>> $urandom_range(1, 10);
            end
            run_op(rx, ry, $sformatf("rnd%0d", k), ang, mag);
            check_model($sformatf("rnd%0d", k), int'(rx), int'(ry), ang, mag);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
